iobuf_pin_seq: RTL

Half-duplex serial sequencer for a single bidirectional pad. It sits directly upstream of the tri-state I/O buffer: it drives the buffer's data input (PAD_I) and active-low enable (PAD_T), and consumes the buffer's input-path output (PAD_O). A host issues one word per transaction, either a write (shift out) or a read (release and shift in), with fixed bit timing and bus turnaround.

---
 rtl/iobuf_pin_seq.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/iobuf_pin_seq.sv
// iobuf_pin_seq: half-duplex serial sequencer for one bidirectional pad.
// Drives the tri-state buffer's data input (PAD_I) and active-low enable
// (PAD_T), and samples the buffer's input path (PAD_O) through a two-flop
// synchronizer. One word per transaction: a write shifts out MSB first, and
// a read releases the pad, waits a turnaround, then shifts in MSB first.
// Every output is a flop, so the pad controls never glitch.
module iobuf_pin_seq #(
   parameter int WIDTH = 8,   // bits per transaction word
   parameter int DIV   = 4,   // clock cycles per bit period
   parameter int TA    = 2    // turnaround cycles with the pad released
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             START,
   input  logic             RW,
   input  logic [WIDTH-1:0] WDATA,
   output logic             BUSY,
   output logic             DONE,
   output logic [WIDTH-1:0] RDATA,
   output logic             PAD_I,
   output logic             PAD_T,
   input  logic             PAD_O
);

   // Counter widths: clog2 of each range, never narrower than one bit.
   localparam int CW = (DIV   > 1) ? $clog2(DIV)   : 1;
   localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int TW = (TA    > 1) ? $clog2(TA)    : 1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WR,
      ST_TURN_WR,
      ST_TURN_RD,
      ST_RD
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] sreg_q,  sreg_d;
   logic [CW-1:0]    cyc_q,   cyc_d;
   logic [BW-1:0]    bit_q,   bit_d;
   logic [TW-1:0]    turn_q,  turn_d;
   logic [WIDTH-1:0] rdata_q, rdata_d;
   logic             pad_t_q, pad_t_d;
   logic             pad_i_q, pad_i_d;
   logic             busy_q,  busy_d;
   logic             done_q,  done_d;
   logic             pin_meta_q;
   logic             pin_s_q;

   logic             cyc_last;
   logic             bit_last;
   logic             turn_last;
   logic [WIDTH-1:0] rd_shift;

   assign cyc_last  = (cyc_q  == CW'(DIV - 1));
   assign bit_last  = (bit_q  == BW'(WIDTH - 1));
   assign turn_last = (turn_q == TW'(TA - 1));

   // Shift register with the synchronized pin appended at the LSB.
   assign rd_shift  = (sreg_q << 1) | WIDTH'(pin_s_q);

   // State, datapath and registered outputs; reset releases the pad at once.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q    <= ST_IDLE;
         sreg_q     <= '0;
         cyc_q      <= '0;
         bit_q      <= '0;
         turn_q     <= '0;
         rdata_q    <= '0;
         pad_t_q    <= 1'b1;
         pad_i_q    <= 1'b1;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         pin_meta_q <= 1'b1;
         pin_s_q    <= 1'b1;
      end else begin
         // NOTE: non-blocking assignments here so every flop samples the
         // pre-edge value of its neighbours, e.g. the two synchronizer stages.
         state_q    <= state_d;
         sreg_q     <= sreg_d;
         cyc_q      <= cyc_d;
         bit_q      <= bit_d;
         turn_q     <= turn_d;
         rdata_q    <= rdata_d;
         pad_t_q    <= pad_t_d;
         pad_i_q    <= pad_i_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         pin_meta_q <= PAD_O;
         pin_s_q    <= pin_meta_q;
      end
   end

   // Next-state and datapath: sequencing of bits, periods and turnarounds.
   always_comb begin
      // NOTE: every signal gets a hold default first so no path through the
      // case statement can leave it unassigned and infer a latch.
      state_d = state_q;
      sreg_d  = sreg_q;
      cyc_d   = cyc_q;
      bit_d   = bit_q;
      turn_d  = turn_q;
      rdata_d = rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (START) begin
               sreg_d  = WDATA;
               cyc_d   = '0;
               bit_d   = '0;
               turn_d  = '0;
               state_d = RW ? ST_TURN_RD : ST_WR;
            end
         end

         ST_WR: begin
            if (cyc_last) begin
               cyc_d  = '0;
               sreg_d = sreg_q << 1;
               if (bit_last) begin
                  bit_d   = '0;
                  state_d = ST_TURN_WR;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end

         ST_TURN_WR: begin
            if (turn_last) begin
               turn_d  = '0;
               state_d = ST_IDLE;
            end else begin
               turn_d = turn_q + TW'(1);
            end
         end

         ST_TURN_RD: begin
            if (turn_last) begin
               turn_d  = '0;
               cyc_d   = '0;
               state_d = ST_RD;
            end else begin
               turn_d = turn_q + TW'(1);
            end
         end

         ST_RD: begin
            if (cyc_last) begin
               cyc_d  = '0;
               sreg_d = rd_shift;
               if (bit_last) begin
                  bit_d   = '0;
                  rdata_d = rd_shift;
                  state_d = ST_IDLE;
               end else begin
                  bit_d = bit_q + BW'(1);
               end
            end else begin
               cyc_d = cyc_q + CW'(1);
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode from the upcoming state, registered on the same edge.
   always_comb begin
      pad_t_d = (state_d != ST_WR);
      pad_i_d = (state_d == ST_WR) ? sreg_d[WIDTH-1] : 1'b1;
      busy_d  = (state_d != ST_IDLE);
      done_d  = (state_q != ST_IDLE) && (state_d == ST_IDLE);
   end

   assign PAD_T = pad_t_q;
   assign PAD_I = pad_i_q;
   assign BUSY  = busy_q;
   assign DONE  = done_q;
   assign RDATA = rdata_q;

endmodule
